maxpool2x2_stage: RTL and testbench
===================================

Name: maxpool2x2_stage

Overview:
Parametrised, multi-channel 2x2/stride-2 max-pooling stage that follows a convolution core in the CNN pipeline.
- Consumes a raster-order feature-map stream, one pixel per valid beat, all channels in parallel.
- Emits the pooled map with its output coordinates.
- Frame sequencing is explicit: start, busy, done pulse and a sticky protocol-error flag, so the parent needs no output counters of its own.

Parameters:
CH, 3, channels carried in parallel per beat
D_BW, 20, signed data width per channel
IW, 24, input map width (even, >=2)
IH, 24, input map height (even, >=2)
OW, IW/2, pooled width (derived, localparam)
OH, IH/2, pooled height (derived, localparam)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; arms a new frame
i_in_valid  in  1  input beat valid
i_in_fmap  in  CH*D_BW  channel c at [c*D_BW +: D_BW], signed
o_ot_valid  out  1  pooled beat valid
o_ot_fmap  out  CH*D_BW  pooled value per channel, same packing
o_ot_x  out  $clog2(OW)  pooled column of current output
o_ot_y  out  $clog2(OH)  pooled row of current output
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse after the last pooled beat of a frame
o_err  out  1  sticky: beat received while not in RUN

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; x/y counters 0; line buffer contents don't-care.
- FSM states and transitions:
  - IDLE: i_start -> RUN.
  - RUN: accepting the beat at (IW-1, IH-1) -> DONE.
  - DONE: lasts one cycle with o_done=1, then -> IDLE.
- i_start handling:
  - Any state: clears x/y counters and the pending horizontal max.
  - A beat arriving in the same cycle as i_start is dropped.
  - i_start in RUN aborts the frame: no o_done, no flush of partial results.
- Beats outside RUN: i_in_valid in IDLE or DONE is ignored and sets o_err. Only reset clears o_err; i_start does not.
- Counters: x advances on each accepted beat and wraps at IW-1; y increments on x wrap. No gaps are required between beats; any duty cycle is legal.
- Even input row (y[0]=0):
  - Even x: latch the pixel into the horizontal register.
  - Odd x: write max(horizontal register, pixel) per channel into line buffer entry x>>1, depth OW x CH x D_BW.
- Odd input row, even x: latch into the horizontal register.
- Odd input row, odd x:
  - Compute m = max(line_buf[x>>1], max(horizontal register, pixel)) per channel, signed compare.
  - Register m: o_ot_valid=1 on the next cycle, o_ot_fmap=m, o_ot_x=x>>1, o_ot_y=y>>1.
- Latency and output pattern:
  - Latency is 1 cycle from the completing beat.
  - o_ot_valid is a single-cycle pulse; no backpressure.
  - Exactly OW*OH outputs per completed frame.
- o_done: asserted the cycle after the final o_ot_valid, i.e. 2 cycles after the last input beat.
- Ties: equal values choose either operand; the result is identical.
- Reset mid-frame: immediate return to IDLE; outputs are 0 on the next edge.

Optional Feature:
MAXPOOL_RELU_EN
- Defined: each pooled channel value is clamped to 0 if negative before registering (fused ReLU).
- Undefined: the raw signed maximum is output.
- Latency is unchanged either way.

Decomposition:
- Shared package cnn_pkg holds:
  - state encoding localparams (ST_IDLE, ST_RUN, ST_DONE);
  - a signed-max function over D_BW;
  - the channel slice helper macro/function for c*D_BW packing.
- One natural sub-module: pool_line_buffer, a simple dual-port RAM with OW entries of CH*D_BW bits, written on even rows and read on odd rows.

Test Plan:
- IW=IH=4, CH=1, D_BW=8; start, then feed 0..15 -> 4 outputs 5,7,13,15 at (0,0),(1,0),(0,1),(1,1); o_done 2 cycles after beat 15.
- Signed data, CH=3: window {-8,-3,-5,-1} on ch0, positive on ch1/ch2 -> ch0 output -1 (RELU_EN undefined); 0 (RELU_EN defined).
- Random valid gaps (30% duty) over a 24x24 frame -> 144 outputs in raster order matching the reference model; o_busy high throughout.
- i_start asserted mid-frame after 50 beats, then a full frame -> no o_done for the aborted frame; second frame yields 144 correct outputs and one o_done.
- i_in_valid pulsed in IDLE -> o_err=1 and stays 1 across a following good frame; reset_n low clears it.
- reset_n asserted mid-frame at beat 300 -> all outputs 0 asynchronously; the next start produces a correct full frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for CNN pipeline stages: FSM state encodings and
// per-channel arithmetic/packing helpers.
package cnn_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Widest channel word the shared max helper handles; callers sign-extend into it.
   localparam int MAX_BW = 64;

   function automatic logic signed [MAX_BW-1:0] signed_max(
      input logic signed [MAX_BW-1:0] a,
      input logic signed [MAX_BW-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   function automatic int ch_lsb(input int c, input int bw);
      return c * bw;
   endfunction

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One row of horizontally pooled pairs, written on even input rows and read
// back (registered) on odd rows.
module pool_line_buffer
   import cnn_pkg::*;
#(
   parameter  int DEPTH = 12,
   parameter  int DW    = 60,
   localparam int AW    = clog2_min1(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/maxpool2x2_stage.sv
// Multi-channel 2x2 / stride-2 max-pooling stage with frame sequencing.
// Define MAXPOOL_RELU_EN to clamp negative pooled values to zero (fused ReLU).
module maxpool2x2_stage
   import cnn_pkg::*;
#(
   parameter  int CH   = 3,
   parameter  int D_BW = 20,
   parameter  int IW   = 24,
   parameter  int IH   = 24,
   localparam int OW   = IW / 2,
   localparam int OH   = IH / 2,
   localparam int OXW  = clog2_min1(OW),
   localparam int OYW  = clog2_min1(OH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_start,
   input  logic                 i_in_valid,
   input  logic [CH*D_BW-1:0]   i_in_fmap,
   output logic                 o_ot_valid,
   output logic [CH*D_BW-1:0]   o_ot_fmap,
   output logic [OXW-1:0]       o_ot_x,
   output logic [OYW-1:0]       o_ot_y,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);

   localparam int XW = clog2_min1(IW);
   localparam int YW = clog2_min1(IH);
   localparam int FW = CH * D_BW;

   logic [1:0]     state;
   logic [XW-1:0]  x_cnt;
   logic [YW-1:0]  y_cnt;
   logic [FW-1:0]  h_reg;
   logic [FW-1:0]  h_max;
   logic [FW-1:0]  pool_max;
   logic [FW-1:0]  lb_rd_data;
   logic           beat_acc;
   logic           x_last;
   logic           y_last;
   logic           lb_wr_en;
   logic           lb_rd_en;
   logic           pool_fire;
   logic [OXW-1:0] x_half;
   logic [OYW-1:0] y_half;

   // A beat coinciding with i_start belongs to no frame and is dropped.
   assign beat_acc  = i_in_valid && !i_start && (state == ST_RUN);
   assign x_last    = (x_cnt == XW'(IW - 1));
   assign y_last    = (y_cnt == YW'(IH - 1));
   assign x_half    = OXW'(x_cnt >> 1);
   assign y_half    = OYW'(y_cnt >> 1);
   assign lb_wr_en  = beat_acc && !y_cnt[0] &&  x_cnt[0];
   assign lb_rd_en  = beat_acc &&  y_cnt[0] && !x_cnt[0];
   assign pool_fire = beat_acc &&  y_cnt[0] &&  x_cnt[0];
   assign o_busy    = (state == ST_RUN);

   // The line-buffer read is issued on the even beat of an odd row so its
   // registered data is ready whenever the matching odd beat arrives.
   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [D_BW-1:0] pix;
      logic signed [D_BW-1:0] held;
      logic signed [D_BW-1:0] above;
      logic signed [D_BW-1:0] hmax;
      logic signed [D_BW-1:0] vmax;

      assign pix   = i_in_fmap[ch_lsb(c, D_BW) +: D_BW];
      assign held  = h_reg[ch_lsb(c, D_BW) +: D_BW];
      assign above = lb_rd_data[ch_lsb(c, D_BW) +: D_BW];
      assign hmax  = D_BW'(signed_max(MAX_BW'(pix), MAX_BW'(held)));
      assign vmax  = D_BW'(signed_max(MAX_BW'(above), MAX_BW'(hmax)));

      assign h_max[ch_lsb(c, D_BW) +: D_BW] = hmax;
`ifdef MAXPOOL_RELU_EN
      assign pool_max[ch_lsb(c, D_BW) +: D_BW] = vmax[D_BW-1] ? '0 : vmax;
`else
      assign pool_max[ch_lsb(c, D_BW) +: D_BW] = vmax;
`endif
   end

   pool_line_buffer #(
      .DEPTH (OW),
      .DW    (FW)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (lb_wr_en),
      .wr_addr (x_half),
      .wr_data (h_max),
      .rd_en   (lb_rd_en),
      .rd_addr (x_half),
      .rd_data (lb_rd_data)
   );

   // i_start from any state restarts the scan; in RUN it silently aborts the frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         x_cnt <= '0;
         y_cnt <= '0;
         h_reg <= '0;
      end else if (i_start) begin
         state <= ST_RUN;
         x_cnt <= '0;
         y_cnt <= '0;
         h_reg <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (beat_acc && x_last && y_last) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         if (beat_acc) begin
            if (!x_cnt[0]) begin
               h_reg <= i_in_fmap;
            end
            if (x_last) begin
               x_cnt <= '0;
               y_cnt <= y_last ? '0 : y_cnt + 1'b1;
            end else begin
               x_cnt <= x_cnt + 1'b1;
            end
         end
      end
   end

   // o_done trails the DONE state by one cycle, landing right after the last pooled beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_ot_valid <= 1'b0;
         o_ot_fmap  <= '0;
         o_ot_x     <= '0;
         o_ot_y     <= '0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_ot_valid <= pool_fire;
         o_done     <= (state == ST_DONE);
         o_err      <= o_err | (i_in_valid && (state != ST_RUN));
         if (pool_fire) begin
            o_ot_fmap <= pool_max;
            o_ot_x    <= x_half;
            o_ot_y    <= y_half;
         end
      end
   end

endmodule

// File: tb/tb_maxpool2x2_stage.sv
// Bench for maxpool2x2_stage on a 6x4, 3-channel, 8-bit map: hand-computed
// windows, random frames with gaps, abort, protocol error and reset mid-frame.
module tb_maxpool2x2_stage;

   localparam int CH   = 3;
   localparam int D_BW = 8;
   localparam int IW   = 6;
   localparam int IH   = 4;
   localparam int OW   = IW / 2;
   localparam int OH   = IH / 2;
   localparam int NPIX = IW * IH;
   localparam int NOUT = OW * OH;

   typedef struct packed {
      logic [11:0][7:0] px;
      logic [2:0][7:0]  ex;
   } win_vec_t;

   typedef struct packed {
      logic [23:0] f;
      logic [1:0]  x;
      logic [0:0]  y;
   } out_t;

   logic              clk;
   logic              reset_n;
   logic              i_start;
   logic              i_in_valid;
   logic [CH*D_BW-1:0] i_in_fmap;
   logic              o_ot_valid;
   logic [CH*D_BW-1:0] o_ot_fmap;
   logic [1:0]        o_ot_x;
   logic [0:0]        o_ot_y;
   logic              o_busy;
   logic              o_done;
   logic              o_err;

   win_vec_t    tbl [NOUT];
   logic [23:0] frame [NPIX];
   out_t        out_q [$];
   int          cyc;
   int          done_cnt;
   int          done_cyc;
   int          last_out_cyc;
   int          busy_bad;
   int          n_checks;
   int          n_fail;
   int          last;

   maxpool2x2_stage #(
      .CH   (CH),
      .D_BW (D_BW),
      .IW   (IW),
      .IH   (IH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_start    (i_start),
      .i_in_valid (i_in_valid),
      .i_in_fmap  (i_in_fmap),
      .o_ot_valid (o_ot_valid),
      .o_ot_fmap  (o_ot_fmap),
      .o_ot_x     (o_ot_x),
      .o_ot_y     (o_ot_y),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_err      (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_ot_valid) begin
         out_q.push_back(out_t'({o_ot_fmap, o_ot_x, o_ot_y}));
         last_out_cyc = cyc;
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   function automatic logic [7:0] relu8(input logic signed [7:0] v);
`ifdef MAXPOOL_RELU_EN
      return (v < 0) ? 8'd0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [23:0] model_fmap(input int ox, input int oy);
      logic [23:0]        r;
      logic signed [7:0]  m;
      logic signed [7:0]  v;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         m = 8'sh80;
         for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
               v = frame[(2*oy + dy)*IW + 2*ox + dx][c*8 +: 8];
               if (v > m) m = v;
            end
         end
         r[c*8 +: 8] = relu8(m);
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_win(input int i, input int c, input int tl, input int tr,
                          input int bl, input int br, input int ex);
      tbl[i].px[c*4 + 0] = 8'(tl);
      tbl[i].px[c*4 + 1] = 8'(tr);
      tbl[i].px[c*4 + 2] = 8'(bl);
      tbl[i].px[c*4 + 3] = 8'(br);
      tbl[i].ex[c]       = 8'(ex);
   endtask

   task automatic fill_random();
      for (int p = 0; p < NPIX; p++) frame[p] = 24'($urandom);
   endtask

   task automatic clear_mon();
      out_q.delete();
      done_cnt = 0;
      busy_bad = 0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic applyStimulus(input int n_beats, input int duty_pct, output int last_cyc);
      int guard;
      last_cyc = 0;
      for (int b = 0; b < n_beats; b++) begin
         guard = 0;
         while (duty_pct < 100 && $urandom_range(99) >= duty_pct && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
         end
         if (!o_busy) busy_bad++;
         i_in_valid = 1'b1;
         i_in_fmap  = frame[b];
         @(posedge clk);
         #1;
         last_cyc   = cyc;
         i_in_valid = 1'b0;
      end
   endtask

   task automatic check_done(input string tag, input int last_cyc);
      checkOutput({tag, "_done_count"}, done_cnt, 1);
      checkOutput({tag, "_last_out_latency"}, last_out_cyc - last_cyc, 0);
      checkOutput({tag, "_done_latency"}, done_cyc - last_cyc, 1);
      checkOutput({tag, "_busy_after"}, o_busy, 0);
   endtask

   task automatic check_frame(input string tag);
      out_t o;
      checkOutput({tag, "_out_count"}, out_q.size(), NOUT);
      for (int i = 0; i < NOUT; i++) begin
         o = (i < out_q.size()) ? out_q[i] : '1;
         checkOutput($sformatf("%s_fmap%0d", tag, i), o.f, model_fmap(i % OW, i / OW));
         checkOutput($sformatf("%s_xy%0d", tag, i), {o.x, o.y}, {2'(i % OW), 1'(i / OW)});
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      i_start    = 1'b0;
      i_in_valid = 1'b0;
      i_in_fmap  = '0;
      clear_mon();

      // Windows in raster order; px order is top-left, top-right, bottom-left, bottom-right.
      set_win(0, 0,    1,    2,    3,    4,    4);
      set_win(0, 1,   -8,   -3,   -5,   -1,   -1);
      set_win(0, 2,  100, -100,    0,    1,  100);
      set_win(1, 0,    9,    5,    6,    7,    9);
      set_win(1, 1, -128, -128, -127, -128, -127);
      set_win(1, 2,   -1,    1,   -2,    0,    1);
      set_win(2, 0,   10,   30,   20,   11,   30);
      set_win(2, 1,   -2,   -9,   -9,   -9,   -2);
      set_win(2, 2,    7,    8, -128,    6,    8);
      set_win(3, 0,    0,    0,  127,  126,  127);
      set_win(3, 1,  -50,  -40,  -60,  -45,  -40);
      set_win(3, 2,   64,  -64,   63,  -63,   64);
      set_win(4, 0,    5,    5,    5,    5,    5);
      set_win(4, 1,   -1,    0,   -1,   -1,    0);
      set_win(4, 2,    0,    0,    0,   -1,    0);
      set_win(5, 0, -128,   -1,   -2,   -3,   -1);
      set_win(5, 1,    3,   -3, -100,    2,    3);
      set_win(5, 2,   -7,   -6,   -5,   -4,   -4);

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", o_ot_valid, 0);
      checkOutput("reset_fmap", o_ot_fmap, 0);
      checkOutput("reset_xy", {o_ot_x, o_ot_y}, 0);
      checkOutput("reset_flags", {o_busy, o_done, o_err}, 0);
      reset_n = 1'b1;
      settle(1);
      checkOutput("idle_busy", o_busy, 0);

      $display("[TB] directed window table");
      for (int y = 0; y < IH; y++) begin
         for (int x = 0; x < IW; x++) begin
            for (int c = 0; c < CH; c++) begin
               frame[y*IW + x][c*8 +: 8] = tbl[(y/2)*OW + x/2].px[c*4 + (y%2)*2 + x%2];
            end
         end
      end
      start_frame();
      checkOutput("busy_after_start", o_busy, 1);
      clear_mon();
      applyStimulus(NPIX, 100, last);
      settle(4);
      checkOutput("tbl_out_count", out_q.size(), NOUT);
      for (int i = 0; i < NOUT; i++) begin
         out_t o;
         o = (i < out_q.size()) ? out_q[i] : '1;
         checkOutput($sformatf("tbl_fmap%0d", i), o.f,
                     {relu8(tbl[i].ex[2]), relu8(tbl[i].ex[1]), relu8(tbl[i].ex[0])});
         checkOutput($sformatf("tbl_xy%0d", i), {o.x, o.y}, {2'(i % OW), 1'(i / OW)});
      end
      check_done("tbl", last);
      checkOutput("tbl_err", o_err, 0);

      $display("[TB] random frame, 30 percent duty");
      fill_random();
      start_frame();
      clear_mon();
      applyStimulus(NPIX, 30, last);
      checkOutput("rand_busy_throughout", busy_bad, 0);
      settle(4);
      check_frame("rand");
      check_done("rand", last);

      $display("[TB] abort mid-frame with a colliding beat");
      fill_random();
      start_frame();
      clear_mon();
      applyStimulus(10, 100, last);
      settle(3);
      checkOutput("abort_partial_outputs", out_q.size(), 2);
      fill_random();
      i_start    = 1'b1;
      i_in_valid = 1'b1;
      i_in_fmap  = 24'h7f7f7f;
      @(posedge clk);
      #1;
      i_start    = 1'b0;
      i_in_valid = 1'b0;
      checkOutput("abort_done_quiet", done_cnt, 0);
      clear_mon();
      applyStimulus(NPIX, 60, last);
      settle(4);
      check_frame("after_abort");
      check_done("after_abort", last);
      checkOutput("abort_err", o_err, 0);

      $display("[TB] beat outside RUN");
      i_in_valid = 1'b1;
      i_in_fmap  = 24'h123456;
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      checkOutput("err_set", o_err, 1);
      fill_random();
      start_frame();
      clear_mon();
      applyStimulus(NPIX, 100, last);
      settle(4);
      check_frame("err_frame");
      checkOutput("err_sticky", o_err, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("err_cleared", o_err, 0);
      #2;
      reset_n = 1'b1;
      settle(1);

      $display("[TB] reset mid-frame");
      fill_random();
      start_frame();
      clear_mon();
      applyStimulus(10, 100, last);
      checkOutput("pre_reset_valid", o_ot_valid, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_valid", o_ot_valid, 0);
      checkOutput("midreset_fmap", o_ot_fmap, 0);
      checkOutput("midreset_xy", {o_ot_x, o_ot_y}, 0);
      checkOutput("midreset_busy", o_busy, 0);
      #2;
      reset_n = 1'b1;
      settle(1);
      fill_random();
      start_frame();
      clear_mon();
      applyStimulus(NPIX, 50, last);
      settle(4);
      check_frame("post_reset");
      check_done("post_reset", last);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
